seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 213 +++++++++++++++++++++
 tb/tb_seg_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// ============================================================================
//  Module   : seg_scan
//  Brief    : Two-digit multiplexed 7-segment scanner (BCD units + mod-6 tens)
//             with pulse-stretched carry/borrow indicator LEDs.
//             Optional macro SEG_SCAN_BLANK_EN blanks a leading tens zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan #(
    parameter int DIV     = 4,
    parameter int STRETCH = 8
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic [3:0] D0,
    input  logic [2:0] D1,
    input  logic       CO,
    input  logic       BO,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       LED_C,
    output logic       LED_B
);

    localparam int               c_PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0]  c_PMAX     = c_PW'(DIV - 1);
    localparam logic [7:0]       c_STRETCH  = 8'(STRETCH);
    localparam logic [0:0]       c_ST_UNITS = 1'b0;
    localparam logic [0:0]       c_ST_TENS  = 1'b1;
    localparam logic [6:0]       c_SEG_OFF  = 7'h00;
    localparam logic [6:0]       c_SEG_DASH = 7'h40;
    localparam logic [1:0]       c_AN_OFF   = 2'b11;
    localparam logic [1:0]       c_AN_UNITS = 2'b10;
    localparam logic [1:0]       c_AN_TENS  = 2'b01;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = c_SEG_DASH;
        endcase
        return s;
    endfunction

    logic [c_PW-1:0] r_pre;
    logic            w_tick;
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            r_first;
    logic            r_upd;
    logic [3:0]      r_d0;
    logic [2:0]      r_d1;
    logic [6:0]      w_seg_nxt;
    logic [1:0]      w_an_nxt;
    logic            r_armed;
    logic [1:0]      w_ev_in;
    logic [1:0]      w_led;

    // ------------------------------------------------------------------
    // Prescaler: one-cycle tick every DIV clocks
    // ------------------------------------------------------------------
    assign w_tick = (r_pre == c_PMAX);

    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan index state machine
    // ------------------------------------------------------------------
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            r_state <= c_ST_UNITS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                c_ST_UNITS: w_state_nxt = c_ST_TENS;
                c_ST_TENS:  w_state_nxt = c_ST_UNITS;
                default:    w_state_nxt = c_ST_UNITS;
            endcase
        end
    end

    // Digits are captured only at frame start (tens->units tick) or on the
    // very first tick, so a frame never shows a mix of old and new inputs.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            r_first <= 1'b1;
            r_upd   <= 1'b0;
            r_d0    <= '0;
            r_d1    <= '0;
        end else begin
            r_upd <= w_tick;
            if (w_tick && (r_first || (r_state == c_ST_TENS))) begin
                r_first <= 1'b0;
                r_d0    <= D0;
                r_d1    <= D1;
            end
        end
    end

    // One cycle after a tick the index has already toggled, so the digit
    // being shown is the one opposite to the current state.
    always_comb begin
        w_seg_nxt = c_SEG_OFF;
        w_an_nxt  = c_AN_OFF;
        case (r_state)
            c_ST_TENS: begin
                w_an_nxt  = c_AN_UNITS;
                w_seg_nxt = f_decode(r_d0);
            end
            c_ST_UNITS: begin
                w_an_nxt = c_AN_TENS;
                if (r_d1 > 3'd5) begin
                    w_seg_nxt = c_SEG_DASH;
                end else begin
`ifdef SEG_SCAN_BLANK_EN
                    if (r_d1 == 3'd0) begin
                        w_seg_nxt = c_SEG_OFF;
                    end else begin
                        w_seg_nxt = f_decode({1'b0, r_d1});
                    end
`else
                    w_seg_nxt = f_decode({1'b0, r_d1});
`endif
                end
            end
            default: begin
                w_seg_nxt = c_SEG_OFF;
                w_an_nxt  = c_AN_OFF;
            end
        endcase
    end

    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            SEG <= c_SEG_OFF;
            AN  <= c_AN_OFF;
        end else if (r_upd) begin
            SEG <= w_seg_nxt;
            AN  <= w_an_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Indicator stretchers: [0] = carry, [1] = borrow
    // ------------------------------------------------------------------
    // r_armed masks the first edge after release so an input already high
    // at that point is not mistaken for a fresh event.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    assign w_ev_in = {BO, CO};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ind
            logic       r_hist;
            logic [7:0] r_cnt;
            logic       w_edge;

            assign w_edge = w_ev_in[gi] & ~r_hist & r_armed;

            always_ff @(posedge CP or posedge CLR) begin
                if (CLR) begin
                    r_hist <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_hist <= w_ev_in[gi];
                    if (w_edge) begin
                        r_cnt <= c_STRETCH;
                    end else if (w_tick && (r_cnt != 8'd0)) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
            end

            assign w_led[gi] = (r_cnt != 8'd0);
        end
    endgenerate

    assign LED_C = w_led[0];
    assign LED_B = w_led[1];

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
// ============================================================================
//  Module   : tb_seg_scan
//  Brief    : Directed self-checking bench for seg_scan (DIV=4, STRETCH=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan;

    logic       cp;
    logic       clr;
    logic [3:0] d0;
    logic [2:0] d1;
    logic       co;
    logic       bo;
    logic [6:0] seg;
    logic [1:0] an;
    logic       led_c;
    logic       led_b;

    int checks = 0;
    int errors = 0;
    int e      = 0;

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    typedef struct {
        logic [3:0] d0;
        logic [2:0] d1;
        logic [6:0] units;
        logic [6:0] tens;
    } vec_t;

    vec_t vecs[8];

    seg_scan #(.DIV(4), .STRETCH(8)) dut (
        .CP   (cp),
        .CLR  (clr),
        .D0   (d0),
        .D1   (d1),
        .CO   (co),
        .BO   (bo),
        .SEG  (seg),
        .AN   (an),
        .LED_C(led_c),
        .LED_B(led_b)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance to the given edge count since release, then sample 1 time unit later.
    task automatic to_edge(input int target);
        while (e < target) begin
            @(posedge cp);
            e++;
        end
        #1;
    endtask

    task automatic start(input logic [3:0] a0, input logic [2:0] a1,
                         input logic c, input logic b);
        clr = 1'b1;
        @(negedge cp);
        d0 = a0;
        d1 = a1;
        co = c;
        bo = b;
        @(negedge cp);
        clr = 1'b0;
        e   = 0;
    endtask

    initial begin
        clr = 1'b1;
        d0  = 4'd0;
        d1  = 3'd0;
        co  = 1'b1;
        bo  = 1'b1;

        vecs[0] = '{4'd7,  3'd5, 7'h07, 7'h6D};
        vecs[1] = '{4'd0,  3'd0, 7'h3F, TENS_ZERO};
        vecs[2] = '{4'd9,  3'd1, 7'h6F, 7'h06};
        vecs[3] = '{4'd12, 3'd6, 7'h40, 7'h40};
        vecs[4] = '{4'd4,  3'd0, 7'h66, TENS_ZERO};
        vecs[5] = '{4'd8,  3'd7, 7'h7F, 7'h40};
        vecs[6] = '{4'd15, 3'd3, 7'h40, 7'h4F};
        vecs[7] = '{4'd2,  3'd4, 7'h5B, 7'h66};

        // Reset state while inputs are active
        repeat (3) @(posedge cp);
        #1;
        chk("rst_seg",   32'(seg),   32'h00);
        chk("rst_an",    32'(an),    32'h3);
        chk("rst_led_c", 32'(led_c), 32'h0);
        chk("rst_led_b", 32'(led_b), 32'h0);

        // Display timing and decoding per vector
        for (int i = 0; i < 8; i++) begin
            start(vecs[i].d0, vecs[i].d1, 1'b0, 1'b0);
            to_edge(4);
            chk($sformatf("v%0d_pre_an", i),  32'(an),  32'h3);
            to_edge(5);
            chk($sformatf("v%0d_u_an", i),    32'(an),  32'h2);
            chk($sformatf("v%0d_u_seg", i),   32'(seg), 32'(vecs[i].units));
            to_edge(8);
            chk($sformatf("v%0d_hold_an", i), 32'(an),  32'h2);
            to_edge(9);
            chk($sformatf("v%0d_t_an", i),    32'(an),  32'h1);
            chk($sformatf("v%0d_t_seg", i),   32'(seg), 32'(vecs[i].tens));
            to_edge(13);
            chk($sformatf("v%0d_r_seg", i),   32'(seg), 32'(vecs[i].units));
        end

        // Mid-frame input changes are held off until the next frame start
        start(4'd3, 3'd2, 1'b0, 1'b0);
        to_edge(5);
        chk("mf_u0", 32'(seg), 32'h4F);
        to_edge(6);
        d0 = 4'd8;
        to_edge(9);
        chk("mf_tens", 32'(seg), 32'h5B);
        to_edge(10);
        d0 = 4'd1;
        to_edge(13);
        chk("mf_u1", 32'(seg), 32'h7F);
        to_edge(17);
        chk("mf_t1", 32'(seg), 32'h5B);
        to_edge(21);
        chk("mf_u2", 32'(seg), 32'h06);

        // Input already high at release is not an event; held high is one event
        start(4'd0, 3'd1, 1'b1, 1'b1);
        to_edge(1);
        chk("rel_led_c1", 32'(led_c), 32'h0);
        chk("rel_led_b1", 32'(led_b), 32'h0);
        to_edge(3);
        chk("rel_led_c3", 32'(led_c), 32'h0);
        co = 1'b0;
        bo = 1'b0;
        to_edge(5);
        co = 1'b1;
        to_edge(6);
        chk("hold_load", 32'(led_c), 32'h1);
        to_edge(35);
        chk("hold_last", 32'(led_c), 32'h1);
        to_edge(36);
        chk("hold_off", 32'(led_c), 32'h0);
        to_edge(48);
        chk("hold_norefire", 32'(led_c), 32'h0);
        chk("hold_led_b", 32'(led_b), 32'h0);
        co = 1'b0;

        // One-cycle pulse, then a retrigger four ticks later
        start(4'd0, 3'd1, 1'b0, 1'b0);
        to_edge(5);
        co = 1'b1;
        to_edge(6);
        co = 1'b0;
        chk("pulse_load", 32'(led_c), 32'h1);
        to_edge(20);
        chk("pulse_mid", 32'(led_c), 32'h1);
        to_edge(21);
        co = 1'b1;
        to_edge(22);
        co = 1'b0;
        to_edge(36);
        chk("retrig_36", 32'(led_c), 32'h1);
        to_edge(51);
        chk("retrig_51", 32'(led_c), 32'h1);
        to_edge(52);
        chk("retrig_52", 32'(led_c), 32'h0);
        chk("retrig_led_b", 32'(led_b), 32'h0);

        // Both pulsed on a tick edge (load beats decrement), then BO alone
        start(4'd0, 3'd1, 1'b0, 1'b0);
        to_edge(7);
        co = 1'b1;
        bo = 1'b1;
        to_edge(8);
        co = 1'b0;
        bo = 1'b0;
        chk("both_c", 32'(led_c), 32'h1);
        chk("both_b", 32'(led_b), 32'h1);
        to_edge(11);
        bo = 1'b1;
        to_edge(12);
        bo = 1'b0;
        to_edge(39);
        chk("both_c39", 32'(led_c), 32'h1);
        chk("both_b39", 32'(led_b), 32'h1);
        to_edge(40);
        chk("both_c40", 32'(led_c), 32'h0);
        chk("both_b40", 32'(led_b), 32'h1);

        // Asynchronous clear mid-stretch
        #2;
        clr = 1'b1;
        #1;
        chk("aclr_led_b", 32'(led_b), 32'h0);
        chk("aclr_an",    32'(an),    32'h3);
        chk("aclr_seg",   32'(seg),   32'h00);
        repeat (4) @(posedge cp);
        #1;
        chk("aclr_hold_an", 32'(an), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
